// File: rtl/emu_pkg.sv
// ---------------------------------------------------------------------------
// emu_pkg
// Shared definitions for the co-emulation stream transactor:
//   - state_e      : step-controller FSM states (IDLE, RUN, CAPTURE)
//   - CNT_W        : width of the enabled-cycle counter (holds 1..256)
//   - STAT_*       : bit positions inside the host-visible status byte
//   - cnt_from_din : converts the 8-bit host step count into a cycle count
// ---------------------------------------------------------------------------
package emu_pkg;

  localparam int CNT_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_CMD_ERR = 3;

  // A host count of zero stands for the full 256-cycle run, which is why the
  // counter needs a ninth bit.
  function automatic logic [CNT_W-1:0] cnt_from_din(input logic [7:0] din);
    logic [CNT_W-1:0] cnt;
    if (din == 8'd0) begin
      cnt = 9'd256;
    end else begin
      cnt = {1'b0, din};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/emu_step_ctrl.sv
// ---------------------------------------------------------------------------
// emu_step_ctrl
// Run controller of the transactor: accepts a step command, enables the DUT
// for a counted number of cycles (or until dut_done in until-done mode),
// then spends one CAPTURE cycle while the top copies the DUT outputs.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   step_cmd          step command that won command arbitration this cycle
//   step_cnt          host step count (0 means 256)
//   step_until_done   until-done mode, sampled with an accepted step_cmd
//   dut_done          DUT completion flag, only looked at while running
//   dut_ce            registered DUT clock enable (high exactly in RUN)
//   busy              registered "not IDLE"
//   capture           high during the CAPTURE cycle
//   done_seen         sticky: run ended on dut_done
//   timeout           sticky: until-done run exhausted its count
//   cmd_err           sticky: step_cmd arrived while busy
// ---------------------------------------------------------------------------
module emu_step_ctrl
  import emu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_cmd,
  input  logic [7:0] step_cnt,
  input  logic       step_until_done,
  input  logic       dut_done,
  output logic       dut_ce,
  output logic       busy,
  output logic       capture,
  output logic       done_seen,
  output logic       timeout,
  output logic       cmd_err
);

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             until_r, until_s;
  logic             done_seen_r, done_seen_s;
  logic             timeout_r, timeout_s;
  logic             cmd_err_r, cmd_err_s;
  logic             dut_ce_r;
  logic             busy_r;

  // State, counter, mode and sticky flags; dut_ce and busy are registered
  // from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      until_r     <= 1'b0;
      done_seen_r <= 1'b0;
      timeout_r   <= 1'b0;
      cmd_err_r   <= 1'b0;
      dut_ce_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      until_r     <= until_s;
      done_seen_r <= done_seen_s;
      timeout_r   <= timeout_s;
      cmd_err_r   <= cmd_err_s;
      dut_ce_r    <= (state_s == ST_RUN);
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  // Next-state, counter and flag update.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    until_s     = until_r;
    done_seen_s = done_seen_r;
    timeout_s   = timeout_r;
    cmd_err_s   = cmd_err_r;

    case (state_r)
      ST_IDLE: begin
        if (step_cmd) begin
          state_s     = ST_RUN;
          cnt_s       = cnt_from_din(step_cnt);
          until_s     = step_until_done;
          done_seen_s = 1'b0;
          timeout_s   = 1'b0;
          cmd_err_s   = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (step_cmd) begin
          cmd_err_s = 1'b1;
        end else begin
          cmd_err_s = cmd_err_r;
        end
        // dut_done wins over the last count, so a simultaneous finish
        // reports done_seen and never timeout.
        if (until_r && dut_done) begin
          state_s     = ST_CAPTURE;
          done_seen_s = 1'b1;
          cnt_s       = {CNT_W{1'b0}};
        end else if (cnt_r <= 9'd1) begin
          // "<= 1" rather than "== 1" keeps the counter from ever wrapping.
          state_s   = ST_CAPTURE;
          timeout_s = timeout_r | until_r;
          cnt_s     = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r - 9'd1;
        end
      end

      ST_CAPTURE: begin
        state_s = ST_IDLE;
        if (step_cmd) begin
          cmd_err_s = 1'b1;
        end else begin
          cmd_err_s = cmd_err_r;
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign dut_ce    = dut_ce_r;
  assign busy      = busy_r;
  assign capture   = (state_r == ST_CAPTURE);
  assign done_seen = done_seen_r;
  assign timeout   = timeout_r;
  assign cmd_err   = cmd_err_r;

endmodule

// File: rtl/emu_stream_transactor.sv
// ---------------------------------------------------------------------------
// emu_stream_transactor
// Co-emulation transactor: double-buffers STIM_BYTES stimulus bytes and
// OUT_BYTES capture bytes behind an 8-bit host port and steps the DUT
// through a clock enable. ADDR_W must satisfy
// 2**ADDR_W >= max(STIM_BYTES, OUT_BYTES+1).
//
// Ports:
//   clk_emu, rst_n_emu  clock and asynchronous active-low reset
//   Din_emu             host write data / step count
//   Dout_emu            registered host read data (1-cycle latency)
//   Addr_emu            host byte address; OUT_BYTES reads the status byte
//   we_emu              write Din_emu into stim_buf[Addr_emu]
//   load_emu            stim_buf -> stim_vec (atomic)
//   get_emu             out_vec -> out_buf
//   step_emu            start a run of Din_emu cycles (0 = 256)
//   until_done_emu      with step_emu: stop early on dut_done
//   stim_vec            stimulus bytes driven to the DUT
//   out_vec             DUT outputs to capture
//   dut_done            DUT completion flag
//   dut_ce              DUT clock enable
//   busy_emu            run controller not idle
// Command priority within one cycle: load > get > step > we.
// ---------------------------------------------------------------------------
module emu_stream_transactor
  import emu_pkg::*;
#(
  parameter int STIM_BYTES = 2,
  parameter int OUT_BYTES  = 3,
  parameter int ADDR_W     = 3
) (
  input  logic                    clk_emu,
  input  logic                    rst_n_emu,
  input  logic [7:0]              Din_emu,
  output logic [7:0]              Dout_emu,
  input  logic [ADDR_W-1:0]       Addr_emu,
  input  logic                    we_emu,
  input  logic                    load_emu,
  input  logic                    get_emu,
  input  logic                    step_emu,
  input  logic                    until_done_emu,
  output logic [8*STIM_BYTES-1:0] stim_vec,
  input  logic [8*OUT_BYTES-1:0]  out_vec,
  input  logic                    dut_done,
  output logic                    dut_ce,
  output logic                    busy_emu
);

  // One extra bit so that a byte count equal to 2**ADDR_W still compares.
  localparam logic [ADDR_W:0] STIM_LIM = (ADDR_W+1)'(STIM_BYTES);
  localparam logic [ADDR_W:0] OUT_LIM  = (ADDR_W+1)'(OUT_BYTES);

  logic [8*STIM_BYTES-1:0] stim_buf_r;
  logic [8*STIM_BYTES-1:0] stim_vec_r;
  logic [8*OUT_BYTES-1:0]  out_buf_r;
  logic [7:0]              dout_r;
  logic [7:0]              rd_s;
  logic [7:0]              status_s;
  logic [ADDR_W:0]         addr_ext_s;

  logic load_s, get_s, step_s, we_s;
  logic busy_s, capture_s, done_seen_s, timeout_s, cmd_err_s;

  // Fixed-priority arbitration: only the highest asserted command acts.
  always_comb begin
    load_s = load_emu;
    get_s  = get_emu  & ~load_emu;
    step_s = step_emu & ~load_emu & ~get_emu;
    we_s   = we_emu   & ~load_emu & ~get_emu & ~step_emu;
  end

  assign addr_ext_s = {1'b0, Addr_emu};

  emu_step_ctrl u_step_ctrl (
    .clk             (clk_emu),
    .rst_n           (rst_n_emu),
    .step_cmd        (step_s),
    .step_cnt        (Din_emu),
    .step_until_done (until_done_emu),
    .dut_done        (dut_done),
    .dut_ce          (dut_ce),
    .busy            (busy_s),
    .capture         (capture_s),
    .done_seen       (done_seen_s),
    .timeout         (timeout_s),
    .cmd_err         (cmd_err_s)
  );

  // Host writes into the stimulus staging buffer; out-of-range bytes drop.
  always_ff @(posedge clk_emu or negedge rst_n_emu) begin
    if (!rst_n_emu) begin
      stim_buf_r <= {(8*STIM_BYTES){1'b0}};
    end else if (we_s && (addr_ext_s < STIM_LIM)) begin
      stim_buf_r[{Addr_emu, 3'b000} +: 8] <= Din_emu;
    end else begin
      stim_buf_r <= stim_buf_r;
    end
  end

  // Atomic transfer of the whole staging buffer to the DUT stimulus.
  always_ff @(posedge clk_emu or negedge rst_n_emu) begin
    if (!rst_n_emu) begin
      stim_vec_r <= {(8*STIM_BYTES){1'b0}};
    end else if (load_s) begin
      stim_vec_r <= stim_buf_r;
    end else begin
      stim_vec_r <= stim_vec_r;
    end
  end

  // Capture buffer: filled by an explicit get or by the end-of-run capture.
  always_ff @(posedge clk_emu or negedge rst_n_emu) begin
    if (!rst_n_emu) begin
      out_buf_r <= {(8*OUT_BYTES){1'b0}};
    end else if (get_s || capture_s) begin
      out_buf_r <= out_vec;
    end else begin
      out_buf_r <= out_buf_r;
    end
  end

  // Status byte assembly.
  always_comb begin
    status_s               = 8'h00;
    status_s[STAT_BUSY]    = busy_s;
    status_s[STAT_DONE]    = done_seen_s;
    status_s[STAT_TIMEOUT] = timeout_s;
    status_s[STAT_CMD_ERR] = cmd_err_s;
  end

  // Host read mux: capture bytes, then the status byte, zero above.
  always_comb begin
    rd_s = 8'h00;
    if (addr_ext_s < OUT_LIM) begin
      rd_s = out_buf_r[{Addr_emu, 3'b000} +: 8];
    end else if (addr_ext_s == OUT_LIM) begin
      rd_s = status_s;
    end else begin
      rd_s = 8'h00;
    end
  end

  // Registered read data.
  always_ff @(posedge clk_emu or negedge rst_n_emu) begin
    if (!rst_n_emu) begin
      dout_r <= 8'h00;
    end else begin
      dout_r <= rd_s;
    end
  end

  assign Dout_emu = dout_r;
  assign stim_vec = stim_vec_r;
  assign busy_emu = busy_s;

endmodule

// File: tb/tb_emu_stream_transactor.sv
module tb_emu_stream_transactor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [2:0]  addr;
  logic        we, load, get, step, until_done;
  logic [15:0] stim_vec;
  logic [23:0] out_vec;
  logic        dut_done, dut_ce, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0]  m_buf [2];
  logic [15:0] m_vec;
  logic [7:0]  m_out [3];

  emu_stream_transactor #(.STIM_BYTES(2), .OUT_BYTES(3), .ADDR_W(3)) dut (
    .clk_emu        (clk),
    .rst_n_emu      (rst_n),
    .Din_emu        (din),
    .Dout_emu       (dout),
    .Addr_emu       (addr),
    .we_emu         (we),
    .load_emu       (load),
    .get_emu        (get),
    .step_emu       (step),
    .until_done_emu (until_done),
    .stim_vec       (stim_vec),
    .out_vec        (out_vec),
    .dut_done       (dut_done),
    .dut_ce         (dut_ce),
    .busy_emu       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    addr = a; din = d; we = 1'b1;
    tick();
    we = 1'b0;
    if (a < 3'd2) m_buf[a[0]] = d;
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
    m_vec = {m_buf[1], m_buf[0]};
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    addr = a;
    tick();
    d = dout;
  endtask

  // Starts a run and counts enabled cycles. done_at: enabled cycle on which
  // dut_done is pulsed (0 = never). err_at: enabled cycle on which a second
  // step is issued (0 = never). dut_done is held high outside enabled cycles.
  task automatic run_step(input int n, input bit ud, input int done_at,
                          input int err_at, output int ce);
    bit finished = 1'b0;
    din = n[7:0]; until_done = ud; step = 1'b1;
    tick();
    step = 1'b0; until_done = 1'b0;
    ce = 0;
    for (int i = 0; i < 700; i++) begin
      if (dut_ce) begin
        ce++;
        dut_done = (ce == done_at);
        step     = (ce == err_at);
        din      = 8'd7;
      end else begin
        dut_done = 1'b1;
        step     = 1'b0;
      end
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      tick();
    end
    dut_done = 1'b0; step = 1'b0;
    chk("run_terminates", {31'd0, finished}, 32'd1);
    m_out[0] = out_vec[7:0]; m_out[1] = out_vec[15:8]; m_out[2] = out_vec[23:16];
  endtask

  task automatic check_run(input string tag, input int n, input bit ud,
                           input int done_at, input int err_at);
    int ce, n_eff, exp_ce;
    bit exp_done, exp_to, exp_err;
    logic [7:0] d;
    n_eff    = (n == 0) ? 256 : n;
    exp_done = ud && (done_at >= 1) && (done_at <= n_eff);
    exp_to   = ud && !exp_done;
    exp_ce   = exp_done ? done_at : n_eff;
    exp_err  = (err_at >= 1) && (err_at <= exp_ce);
    run_step(n, ud, done_at, err_at, ce);
    chk({tag, "_ce_cycles"}, ce, exp_ce);
    for (int k = 0; k < 3; k++) begin
      rd(k[2:0], d);
      chk({tag, "_out_byte"}, {24'd0, d}, {24'd0, m_out[k]});
    end
    rd(3'd3, d);
    chk({tag, "_status"}, {24'd0, d}, {28'd0, exp_err, exp_to, exp_done, 1'b0});
  endtask

  initial begin
    logic [7:0] d;
    rst_n = 1'b0; din = 8'h00; addr = 3'd0; we = 1'b0; load = 1'b0; get = 1'b0;
    step = 1'b0; until_done = 1'b0; out_vec = 24'h000000; dut_done = 1'b0;
    m_buf[0] = 8'h00; m_buf[1] = 8'h00; m_vec = 16'h0000;
    for (int k = 0; k < 3; k++) m_out[k] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Reset state.
    chk("rst_stim_vec", {16'd0, stim_vec}, 32'd0);
    chk("rst_dut_ce", {31'd0, dut_ce}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rd(3'd3, d);
    chk("rst_status", {24'd0, d}, 32'd0);
    rd(3'd0, d);
    chk("rst_out0", {24'd0, d}, 32'd0);

    // Write stimulus then load.
    wr(3'd0, 8'hA5);
    wr(3'd1, 8'h3C);
    chk("stim_before_load", {16'd0, stim_vec}, 32'd0);
    do_load();
    chk("stim_after_load", {16'd0, stim_vec}, 32'h3CA5);

    // Counted run with capture.
    out_vec = 24'h123456;
    check_run("counted5", 5, 1'b0, 0, 0);
    // Until-done stopped on 3rd enabled cycle, then run-out timeout.
    check_run("until_done3", 10, 1'b1, 3, 0);
    check_run("until_timeout", 10, 1'b1, 0, 0);
    // Done on the last count: done_seen only.
    check_run("until_last", 4, 1'b1, 4, 0);
    // Step while busy: ignored, cmd_err set; next run clears it.
    check_run("busy_step", 6, 1'b0, 0, 2);
    check_run("clear_err", 2, 1'b0, 0, 0);

    // load beats we in the same cycle.
    addr = 3'd0; din = 8'hEE; we = 1'b1; load = 1'b1;
    tick();
    we = 1'b0; load = 1'b0;
    m_vec = {m_buf[1], m_buf[0]};
    do_load();
    chk("load_over_we", {16'd0, stim_vec}, {16'd0, m_vec});
    // get beats step; get copies out_vec.
    out_vec = 24'hABCDEF; din = 8'd4; step = 1'b1; get = 1'b1;
    tick();
    step = 1'b0; get = 1'b0;
    chk("get_over_step_busy", {31'd0, busy}, 32'd0);
    rd(3'd0, d);
    chk("get_copies", {24'd0, d}, 32'h000000EF);
    // Out-of-range write ignored, out-of-range read is zero.
    wr(3'd5, 8'hFF);
    do_load();
    chk("oob_write", {16'd0, stim_vec}, {16'd0, m_vec});
    rd(3'd6, d);
    chk("oob_read", {24'd0, d}, 32'd0);

    // Randomised transactions against the model.
    for (int it = 0; it < 8; it++) begin
      int n, da, ea;
      bit ud;
      wr(3'($urandom_range(0, 4)), 8'($urandom));
      wr(3'($urandom_range(0, 1)), 8'($urandom));
      do_load();
      chk("rand_stim", {16'd0, stim_vec}, {16'd0, m_vec});
      out_vec = 24'($urandom);
      n  = $urandom_range(1, 20);
      ud = 1'($urandom);
      da = $urandom_range(0, 24);
      ea = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      check_run("rand_run", n, ud, da, ea);
    end

    // Reset in the middle of a run.
    out_vec = 24'h778899;
    din = 8'd8; step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    chk("midrun_ce_high", {31'd0, dut_ce}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_ce", {31'd0, dut_ce}, 32'd0);
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst_stim", {16'd0, stim_vec}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    m_buf[0] = 8'h00; m_buf[1] = 8'h00; m_vec = 16'h0000;
    rd(3'd1, d);
    chk("midrun_rst_out", {24'd0, d}, 32'd0);
    rd(3'd3, d);
    chk("midrun_rst_status", {24'd0, d}, 32'd0);
    do_load();
    chk("midrun_rst_buf", {16'd0, stim_vec}, 32'd0);
    // Step count 0 means 256 enabled cycles.
    check_run("full256", 0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/emu_stream_transactor.md
Name: emu_stream_transactor

Overview:
Parametrised co-emulation transactor, the successor to the fixed 2-in/3-out byte wrapper. It double-buffers N stimulus bytes and M capture bytes behind an 8-bit host port, and drives a DUT clock-enable so the host can step the DUT a counted number of cycles, or run until the DUT's done flag. Auto-capture and a status byte remove per-cycle host round-trips.

Parameters:
STIM_BYTES, 2, number of 8-bit stimulus registers (stim_vec width = 8*STIM_BYTES)
OUT_BYTES, 3, number of 8-bit capture registers (out_vec width = 8*OUT_BYTES)
ADDR_W, 3, host address width; must satisfy 2**ADDR_W >= max(STIM_BYTES, OUT_BYTES+1)

Ports:
clk_emu  in  1  single clock for host interface, FSM and DUT (DUT clocked on clk_emu, gated by dut_ce)
rst_n_emu  in  1  asynchronous, active-low reset
Din_emu  in  8  host write data / step count
Dout_emu  out  8  registered host read data
Addr_emu  in  ADDR_W  host byte address
we_emu  in  1  write Din_emu to stim_buf[Addr_emu]
load_emu  in  1  copy stim_buf to stim_vec
get_emu  in  1  copy out_vec to out_buf
step_emu  in  1  start run; count = Din_emu (0 means 256)
until_done_emu  in  1  sampled with step_emu; 1 = stop early on dut_done
stim_vec  out  8*STIM_BYTES  active stimulus to DUT; byte k = stim_buf[k]
out_vec  in  8*OUT_BYTES  DUT outputs to capture; byte k -> out_buf[k]
dut_done  in  1  DUT completion flag (e.g. ap_done)
dut_ce  out  1  DUT clock enable
busy_emu  out  1  FSM not IDLE

Behaviour:
- Reset (async assert, sync release): stim_buf, stim_vec, out_buf, Dout_emu, status = 0; dut_ce = 0; FSM = IDLE; counter = 0.
- Command priority per cycle: load > get > step > we. Only the highest-priority asserted command executes.
- we: stim_buf[Addr_emu] <= Din_emu; Addr_emu >= STIM_BYTES is ignored.
- Read: every cycle, Dout_emu <= out_buf[Addr_emu] if Addr_emu < OUT_BYTES; status byte if Addr_emu == OUT_BYTES; else 0. Latency is 1 cycle.
- Status byte: bit0 busy, bit1 done_seen, bit2 timeout, bit3 cmd_err; bits 7:4 = 0. done_seen, timeout and cmd_err are sticky; a step accepted in IDLE clears all three.
- load: stim_vec updates 1 cycle after load_emu, all bytes atomically. Allowed while busy: the DUT sees the new stimulus on the next enabled edge.
- get: out_buf <= out_vec, 1 cycle. Allowed while busy.
- FSM IDLE: on step_emu, cnt <= (Din_emu==0 ? 256 : Din_emu), latch until_done_emu, go RUN.
- FSM RUN: dut_ce = 1 each cycle; cnt decrements.
  - Until-done mode with dut_done = 1: go CAPTURE, set done_seen. dut_ce is 0 from the next cycle.
  - cnt reaches 1 without that stop: go CAPTURE after this enabled cycle. Set timeout only if until-done mode.
  - Exactly N enabled cycles in counted mode; at most N in until-done mode.
- FSM CAPTURE: dut_ce = 0; out_buf <= out_vec; go IDLE. busy deasserts the cycle after CAPTURE.
- step_emu while busy: ignored, cmd_err set.
- Simultaneous dut_done and last count in until-done mode: done_seen = 1, timeout = 0.
- dut_done outside RUN: ignored.
- Reset mid-RUN: dut_ce drops asynchronously; all state cleared.
- Counter width is 9 bits; it never wraps.

Decomposition:
- Package emu_pkg: FSM state enum (IDLE, RUN, CAPTURE), status bit index constants, cnt width constant (9).
- One sub-module, emu_step_ctrl: FSM + counter + dut_ce/status flags.
- Top module holds the byte buffers and host mux.

Test Plan:
- Reset then read Addr_emu=3 (status) -> Dout_emu=0x00; stim_vec=0, dut_ce=0.
- Write 0xA5@0, 0x3C@1, pulse load -> stim_vec=16'h3CA5 one cycle later; before load stim_vec unchanged.
- step_emu with Din_emu=5, until_done=0 -> dut_ce high exactly 5 cycles, CAPTURE copies out_vec=24'h123456 so reads of 0/1/2 return 56/34/12; status=0x00 afterwards.
- step Din=10, until_done=1, dut_done pulsed on 3rd enabled cycle -> dut_ce high 3 cycles, status=0x02; with no dut_done -> 10 cycles, status=0x04.
- step_emu issued while busy -> ignored, run length unchanged, status bit3 set; next accepted step clears it.
- Assert rst_n_emu low mid-RUN (cycle 2 of 8) -> dut_ce 0 immediately, busy 0, buffers 0; step Din=0 afterwards -> 256 enabled cycles.
